// File: rtl/typed_stream_pkg.sv
// Shared definitions for the typed narrow-beat stream sender/unpacker pair.
// Holds the unpacker state encoding and the beat-count helper.
package typed_stream_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    DRAIN   = 2'd2
  } unpack_state_e;

  function automatic int beats_for(int bits, int w);
    return (bits + w - 1) / w;
  endfunction

endpackage

// File: rtl/typed_stream_unpacker_if.sv
// Beat-in / value-out bundle of the typed stream unpacker.
// The slave modport is the unpacker's view, master is the surrounding logic.
interface typed_stream_unpacker_if #(
  parameter type PAYLOAD_T = logic [31:0],
  parameter int  BEAT_W    = 8
);
  import typed_stream_pkg::*;

  localparam int N_BEATS = beats_for($bits(PAYLOAD_T), BEAT_W);
  localparam int CNT_W   = $clog2(N_BEATS + 1);

  logic              in_valid;
  logic              in_ready;
  logic [BEAT_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  PAYLOAD_T          out_data;
  logic              err_len;
  logic [CNT_W-1:0]  beat_cnt;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, err_len, beat_cnt
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, err_len, beat_cnt
  );

endinterface

// File: rtl/typed_beat_shreg.sv
// Beat-indexed assembly buffer: one beat written per cycle at wr_idx, clr wins over write.
// Written data is visible on par_dat the cycle after the write; no backpressure of its own.
module typed_beat_shreg #(
  parameter  int BEAT_W  = 8,
  parameter  int N_BEATS = 4,
  localparam int IDX_W   = $clog2(N_BEATS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [IDX_W-1:0]            wr_idx,
  input  logic [BEAT_W-1:0]           wr_dat,
  input  logic                        clr,
  output logic [N_BEATS*BEAT_W-1:0]   par_dat
);

  logic [N_BEATS*BEAT_W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = '0;
    end else if (wr_en) begin
      for (int i = 0; i < N_BEATS; i++) begin
        if (wr_idx == IDX_W'(i)) data_d[i*BEAT_W +: BEAT_W] = wr_dat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign par_dat = data_q;

endmodule

// File: rtl/typed_stream_unpacker.sv
// Reassembles one PAYLOAD_T from LSB-first BEAT_W beats; value valid 1 cycle after the final beat.
// in_ready drops while a value is held; wrong-length packets pulse err_len and are dropped.
module typed_stream_unpacker
  import typed_stream_pkg::*;
#(
  parameter type PAYLOAD_T = logic [31:0],
  parameter int  BEAT_W    = 8
) (
  input  logic clk,
  input  logic rst,
  typed_stream_unpacker_if.slave bus
);

  typedef PAYLOAD_T payload_t;

  localparam int N_BEATS = beats_for($bits(PAYLOAD_T), BEAT_W);
  localparam int CNT_W   = $clog2(N_BEATS + 1);

  unpack_state_e             state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      out_valid_q, out_valid_d;
  logic                      err_len_q, err_len_d;
  logic                      wr_en, clr, accept;
  logic [N_BEATS*BEAT_W-1:0] shreg_dat;

  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    err_len_d   = 1'b0;
    wr_en       = 1'b0;
    clr         = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (accept) begin
          wr_en = 1'b1;
          if (cnt_q == CNT_W'(N_BEATS - 1)) begin
            if (bus.in_last) begin
              state_d     = HOLD;
              out_valid_d = 1'b1;
              cnt_d       = CNT_W'(N_BEATS);
            end else begin
              // Overlong packet: flag once, then swallow the rest up to in_last.
              state_d   = DRAIN;
              err_len_d = 1'b1;
              cnt_d     = '0;
            end
          end else if (bus.in_last) begin
            err_len_d = 1'b1;
            clr       = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (accept && bus.in_last) state_d = COLLECT;
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d     = COLLECT;
          out_valid_d = 1'b0;
          cnt_d       = '0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      err_len_q   <= err_len_d;
    end
  end

  typed_beat_shreg #(
    .BEAT_W  (BEAT_W),
    .N_BEATS (N_BEATS)
  ) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_idx  (cnt_q),
    .wr_dat  (bus.in_data),
    .clr     (clr),
    .par_dat (shreg_dat)
  );

  // Buffer is frozen in HOLD (in_ready=0), so it can drive out_data directly.
  assign bus.in_ready  = (state_q != HOLD);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = payload_t'(shreg_dat[$bits(PAYLOAD_T)-1:0]);
  assign bus.err_len   = err_len_q;
  assign bus.beat_cnt  = cnt_q;

endmodule
